// File: rtl/risc_pkg.sv
// Shared types for the 16-bit RISC fetch/execute sequencer: opcodes, FSM states,
// default widths and the decoded control vector.
package risc_pkg;

    localparam int RISC_ADDR_W    = 16;
    localparam int RISC_MEM_DEPTH = 256;
    localparam int RISC_OPC_W     = 6;
    localparam int RISC_IMM_W     = 10;
    localparam int RISC_DATA_W    = 16;
    localparam int RISC_INSTR_W   = RISC_OPC_W + RISC_IMM_W;

    typedef enum logic [RISC_OPC_W-1:0] {
        OPC_NOP     = 6'h00,
        OPC_LOADA   = 6'h01,
        OPC_LOADB   = 6'h02,
        OPC_ADD     = 6'h03,
        OPC_READOUT = 6'h04,
        OPC_HALT    = 6'h3F
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_WAIT_OUT,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic alu_add;
        logic readout;
        logic halt;
        logic illegal;
    } ctrl_t;

    function automatic logic [RISC_OPC_W-1:0] opcode_of(input logic [RISC_INSTR_W-1:0] instr);
        return instr[RISC_INSTR_W-1 -: RISC_OPC_W];
    endfunction

    function automatic logic [RISC_IMM_W-1:0] operand_of(input logic [RISC_INSTR_W-1:0] instr);
        return instr[RISC_IMM_W-1:0];
    endfunction

endpackage

// File: rtl/risc_decoder.sv
// Combinational opcode decoder; at most one of the datapath strobes is ever set,
// and anything outside the defined opcode set is flagged illegal.
module risc_decoder
    import risc_pkg::*;
(
    input  logic [RISC_OPC_W-1:0] opcode,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_NOP:     ;
            OPC_LOADA:   ctrl.ld_a    = 1'b1;
            OPC_LOADB:   ctrl.ld_b    = 1'b1;
            OPC_ADD:     ctrl.alu_add = 1'b1;
            OPC_READOUT: ctrl.readout = 1'b1;
            OPC_HALT:    ctrl.halt    = 1'b1;
            default:     ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc_control_unit.sv
// Fetch/execute sequencer: owns PC and IR, walks FETCH/EXEC/WAIT_OUT and issues
// one-cycle strobes decoded from the registered instruction only.
module risc_control_unit
    import risc_pkg::*;
#(
    parameter int ADDR_W    = RISC_ADDR_W,
    parameter int MEM_DEPTH = RISC_MEM_DEPTH,
    parameter int OPC_W     = RISC_OPC_W,
    parameter int IMM_W     = RISC_IMM_W,
    parameter int DATA_W    = RISC_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic [OPC_W+IMM_W-1:0]    imem_instr,
    output logic                      ld_a,
    output logic                      ld_b,
    output logic                      alu_add,
    output logic [DATA_W-1:0]         imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      halted,
    output logic                      illegal
);

    localparam int INSTR_W = OPC_W + IMM_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_e               state_reg, state_next;
    logic [ADDR_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0]   ir_reg, ir_next;
    logic                 illegal_reg, illegal_next;
    ctrl_t                ctrl;
    logic                 at_last_addr;

    risc_decoder u_decoder (
        .opcode (ir_reg[INSTR_W-1 -: OPC_W]),
        .ctrl   (ctrl)
    );

    // Execution stops after the last valid word instead of wrapping to address 0.
    assign at_last_addr = (pc_reg == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= '0;
            ir_reg      <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            illegal_reg <= illegal_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        illegal_next = illegal_reg;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        alu_add      = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = ST_FETCH;
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
                if (start) begin
                    pc_next      = '0;
                    illegal_next = 1'b0;
                    state_next   = ST_FETCH;
                end
            end

            ST_FETCH: begin
                busy       = 1'b1;
                ir_next    = imem_instr;
                state_next = ST_EXEC;
            end

            ST_EXEC: begin
                busy    = 1'b1;
                ld_a    = ctrl.ld_a;
                ld_b    = ctrl.ld_b;
                alu_add = ctrl.alu_add;
                if (ctrl.illegal) begin
                    illegal_next = 1'b1;
                    state_next   = ST_HALTED;
                end else if (ctrl.halt) begin
                    state_next = ST_HALTED;
                end else if (ctrl.readout) begin
                    state_next = ST_WAIT_OUT;
                end else if (at_last_addr) begin
                    state_next = ST_HALTED;
                end else begin
                    pc_next    = pc_reg + ADDR_W'(1);
                    state_next = ST_FETCH;
                end
            end

            ST_WAIT_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // The transfer happens on the ready cycle; PC advance follows the EXEC rule.
                if (out_ready) begin
                    if (at_last_addr) begin
                        state_next = ST_HALTED;
                    end else begin
                        pc_next    = pc_reg + ADDR_W'(1);
                        state_next = ST_FETCH;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign imem_addr = pc_reg;
    assign imm       = {{(DATA_W-IMM_W){1'b0}}, ir_reg[IMM_W-1:0]};
    assign illegal   = illegal_reg;

endmodule

// File: doc/risc_control_unit.md
Name: risc_control_unit

Overview:
Fetch/execute sequencer for the 16-bit RISC core. It drives the instruction memory address (program counter) and latches the returned word into an instruction register. It then decodes the 6-bit opcode / 10-bit operand and issues one-cycle control strobes to the A/B register file, the adder and the output port. It sits between instruction_memory and the datapath and owns all program flow.

Parameters:
ADDR_W, 16, width of program counter / imem address
MEM_DEPTH, 256, number of instruction words; the last valid address is MEM_DEPTH-1
OPC_W, 6, opcode field width (instr[15:10])
IMM_W, 10, operand field width (instr[9:0])
DATA_W, 16, datapath width; operand is zero-extended to this

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins execution from address 0 when idle or halted
imem_addr  out  ADDR_W  instruction memory address (PC)
imem_instr  in  16  instruction word; combinational read of imem_addr
ld_a  out  1  load register A with imm
ld_b  out  1  load register B with imm
alu_add  out  1  A <= A + B strobe
imm  out  DATA_W  zero-extended operand of the current instruction
out_valid  out  1  READOUT data valid to the output port
out_ready  in  1  output port accepts
busy  out  1  high in FETCH/EXEC/WAIT_OUT
halted  out  1  high in HALTED
illegal  out  1  sticky: halted on an undefined opcode

Behaviour:
- Opcodes: NOP=0, LOADA=1, LOADB=2, ADD=3, READOUT=4, HALT=6'h3F. All others are illegal.
- States: IDLE, FETCH, EXEC, WAIT_OUT, HALTED.
- Reset (async, immediate): state IDLE, PC=0, IR=0, illegal=0. All strobes, out_valid, busy and halted are 0 while rst is high and on the first cycle after.
- IDLE: on start, go to FETCH with PC=0.
- HALTED: on start, go to FETCH with PC=0 and clear illegal.
- FETCH (1 cycle): IR <= imem_instr; go to EXEC.
- EXEC (1 cycle): decode IR only; there is no combinational path from imem_instr to any strobe.
  - LOADA: ld_a=1. LOADB: ld_b=1. ADD: alu_add=1. NOP: no strobe.
  - READOUT: go to WAIT_OUT; no strobe in EXEC.
  - HALT: go to HALTED, PC unchanged.
  - Illegal opcode: no strobe; set illegal; go to HALTED.
  - Otherwise: if PC==MEM_DEPTH-1, go to HALTED (no wrap); else PC<=PC+1 and go to FETCH.
- WAIT_OUT:
  - out_valid=1, derived from state only (no ready-to-valid path).
  - Stay until out_ready=1; on that cycle the transfer occurs.
  - Then apply the same PC advance / last-address rule as EXEC.
- imm = {zeros, IR[9:0]} is stable throughout EXEC and WAIT_OUT; ld_a, ld_b and alu_add are mutually exclusive.
- Throughput: 2 cycles per non-READOUT instruction; READOUT takes 3 cycles plus stall cycles.
- start while busy is ignored.
- Reset during WAIT_OUT drops out_valid asynchronously; no transfer is counted.
- imem_addr equals the PC register at all times.

Decomposition:
- risc_pkg holds: opcode enum (OPC_NOP..OPC_HALT), state enum, width localparams and a control-vector struct {ld_a, ld_b, alu_add, readout, halt, illegal}.
- Sub-module risc_decoder: purely combinational, opcode -> control-vector struct. The sequencer FSM and PC/IR live in risc_control_unit.

Test Plan:
- Program LOADA 45, LOADB 54, ADD, READOUT, HALT; start at cycle 0; out_ready=1 ->
  - ld_a with imm=45 at EXEC of PC 0; ld_b with imm=54 at PC 1; alu_add at PC 2.
  - out_valid for 1 cycle at PC 3.
  - halted=1 with PC=4; 11 cycles from start to halted; illegal=0.
- Same program, out_ready held low 3 cycles -> out_valid high 4 cycles, PC held at 3, no strobes; advances after the ready cycle.
- Opcode 6'h07 at address 1 -> no strobe in that EXEC, illegal=1, halted=1, PC=1. Re-start -> illegal clears, fetch from 0.
- NOPs filling all 256 words -> halts after executing address 255, PC=255, never reads address 0 again.
- Assert rst during WAIT_OUT -> out_valid, busy and imem_addr drop to 0 in the same cycle; the FSM stays IDLE until start.
- start pulsed while in EXEC of LOADB -> ignored: PC sequence and strobes unchanged versus the reference run.
